// File: rtl/sme_param.sv
// sme_param: loads a string and a pattern (^ $ . metas), then scans start positions for the earliest match.
// Latency: hit at start k -> valid k+1 cycles after SEARCH entry; miss -> valid Ls cycles after entry.
// Backpressure: none; chardata is dropped while SEARCH runs. Build macro SME_NOCASE_EN: case-insensitive letters.
module sme_param #(
  parameter int CHAR_W  = 8,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int IDX_W   = $clog2(STR_MAX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index,
  output logic              error,
  output logic              busy
);
  localparam int LS_W = $clog2(STR_MAX + 1);
  localparam int LP_W = $clog2(PAT_MAX + 1);
  localparam int PI_W = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  localparam logic [CHAR_W-1:0] CH_CARET  = CHAR_W'(8'h5E);
  localparam logic [CHAR_W-1:0] CH_DOLLAR = CHAR_W'(8'h24);
  localparam logic [CHAR_W-1:0] CH_DOT    = CHAR_W'(8'h2E);
  localparam logic [CHAR_W-1:0] CH_SPACE  = CHAR_W'(8'h20);

  typedef enum logic [2:0] {IDLE, RD_STR, RD_PAT, SEARCH, DONE} state_t;

  state_t            state_q, state_d;
  logic [CHAR_W-1:0] str [STR_MAX];
  logic [CHAR_W-1:0] pat [PAT_MAX];
  logic [LS_W-1:0]   ls;
  logic [LP_W-1:0]   lp;
  logic              str_ovf, pat_ovf;
  logic [IDX_W-1:0]  k;

  logic              has_caret, has_dollar;
  logic              body_ok, caret_ok, dollar_ok, hit, last_k, no_search;
  int                ls_i, lp_i, lb_i, k_i;

`ifdef SME_NOCASE_EN
  function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
    if (c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A)) return c | CHAR_W'(8'h20);
    return c;
  endfunction
`endif

  // '.' in the pattern body is a wildcard; everything else compares as a literal.
  function automatic logic chr_eq(input logic [CHAR_W-1:0] p, input logic [CHAR_W-1:0] s);
    if (p == CH_DOT) return 1'b1;
`ifdef SME_NOCASE_EN
    return fold(p) == fold(s);
`else
    return p == s;
`endif
  endfunction

  assign valid = (state_q == DONE);
  assign busy  = (state_q == SEARCH) || (state_q == DONE);

  // Anchor decode and the parallel body compare for the current start position k.
  always_comb begin
    ls_i       = int'(ls);
    lp_i       = int'(lp);
    k_i        = int'(k);
    has_caret  = (lp_i != 0) && (pat[0] == CH_CARET);
    has_dollar = (lp_i != 0) && (pat[PI_W'(lp_i - 1)] == CH_DOLLAR);
    lb_i       = lp_i - int'(has_caret) - int'(has_dollar);
    body_ok    = 1'b1;
    for (int j = 0; j < PAT_MAX; j++) begin
      if (j < lb_i) begin
        if (!chr_eq(pat[PI_W'(j + int'(has_caret))],
                    (k_i + j < STR_MAX) ? str[IDX_W'(k_i + j)] : '0))
          body_ok = 1'b0;
      end
    end
    caret_ok  = !has_caret || (k_i == 0) || (str[IDX_W'(k_i - 1)] == CH_SPACE);
    dollar_ok = !has_dollar || (k_i + lb_i == ls_i) ||
                ((k_i + lb_i < STR_MAX) && (str[IDX_W'(k_i + lb_i)] == CH_SPACE));
    hit       = (k_i + lb_i <= ls_i) && body_ok && caret_ok && dollar_ok;
    last_k    = (k_i == ls_i - 1);
    no_search = (ls_i == 0) || (lb_i <= 0) || str_ovf || pat_ovf;
  end

  // Next-state: isstring beats ispattern; DONE is the single result cycle but can start a new burst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (isstring) state_d = RD_STR;
               else if (ispattern) state_d = RD_PAT;
      RD_STR:  if (isstring) state_d = RD_STR;
               else if (ispattern) state_d = RD_PAT;
               else state_d = IDLE;
      RD_PAT:  if (isstring) state_d = RD_STR;
               else if (!ispattern) state_d = no_search ? DONE : SEARCH;
      SEARCH:  if (hit || last_k) state_d = DONE;
      DONE:    if (isstring) state_d = RD_STR;
               else if (ispattern) state_d = RD_PAT;
               else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, string/pattern capture with sticky overflow, scan position and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < STR_MAX; i++) str[i] <= '0;
      for (int i = 0; i < PAT_MAX; i++) pat[i] <= '0;
      ls          <= '0;
      lp          <= '0;
      str_ovf     <= 1'b0;
      pat_ovf     <= 1'b0;
      k           <= '0;
      match       <= 1'b0;
      match_index <= '0;
      error       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != SEARCH && isstring) begin
        if (state_q != RD_STR) begin
          for (int i = 0; i < STR_MAX; i++) str[i] <= (i == 0) ? chardata : '0;
          ls      <= LS_W'(1);
          str_ovf <= 1'b0;
        end else if (ls_i < STR_MAX) begin
          str[IDX_W'(ls)] <= chardata;
          ls              <= ls + LS_W'(1);
        end else begin
          str_ovf <= 1'b1;
        end
      end else if (state_q != SEARCH && ispattern) begin
        if (state_q != RD_PAT) begin
          for (int i = 0; i < PAT_MAX; i++) pat[i] <= (i == 0) ? chardata : '0;
          lp      <= LP_W'(1);
          pat_ovf <= 1'b0;
        end else if (lp_i < PAT_MAX) begin
          pat[PI_W'(lp)] <= chardata;
          lp             <= lp + LP_W'(1);
        end else begin
          pat_ovf <= 1'b1;
        end
      end
      if (state_q == SEARCH) k <= k + IDX_W'(1);
      else k <= '0;
      if (state_d == DONE && state_q != DONE) begin
        match       <= (state_q == SEARCH) && hit;
        match_index <= ((state_q == SEARCH) && hit) ? k : '0;
        error       <= str_ovf | pat_ovf;
      end
    end
  end
endmodule

// File: tb/tb_sme_param.sv
// tb_sme_param: directed string/pattern bursts with a result scoreboard for sme_param.
// Expected results (match, index, error, cycles from busy rise to valid) are queued at issue time.
// A negedge monitor pops and compares on every valid pulse.
module tb_sme_param;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       chardata;
  logic             isstring, ispattern;
  logic             valid, match, error, busy;
  logic [IDX_W-1:0] match_index;

  typedef struct {int m; int idx; int err; int lat;} exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit busy_prev = 1'b0;

  sme_param dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .valid(valid), .match(match),
    .match_index(match_index), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: latency counted from the first busy cycle (0) to the valid cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cyc = 0;
        busy_prev = 1'b0;
      end else begin
        if (busy && !busy_prev) cyc = 0;
        else if (busy) cyc++;
        busy_prev = busy;
        if (valid) begin
          if (q.size() == 0) chk("unexpected_valid", 1, 0);
          else begin
            e = q.pop_front();
            chk("match", int'(match), e.m);
            chk("match_index", int'(match_index), e.idx);
            chk("error", int'(error), e.err);
            chk("latency", cyc, e.lat);
          end
        end
      end
    end
  end

  task automatic send(input string s, input bit is_str);
    for (int i = 0; i < s.len(); i++) begin
      chardata  = s[i];
      isstring  = is_str;
      ispattern = !is_str;
      @(posedge clk); #1;
    end
    chardata  = '0;
    isstring  = 1'b0;
    ispattern = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      chk("result_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Optional string (empty = keep stored string), then pattern; check result and its hold afterwards.
  task automatic run(input string s, input string p, input int m, input int idx,
                     input int err, input int lat);
    exp_t e;
    e.m = m; e.idx = idx; e.err = err; e.lat = lat;
    q.push_back(e);
    if (s.len() != 0) send(s, 1'b1);
    send(p, 1'b0);
    drain();
    @(posedge clk); #1;
    chk("hold_match", int'(match), m);
    chk("hold_index", int'(match_index), idx);
    chk("hold_error", int'(error), err);
  endtask

  initial begin
    exp_t e;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; chardata = '0; isstring = 1'b0; ispattern = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_index", int'(match_index), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run("hello world", "wor", 1, 6, 0, 7);
    run("", "^wo", 1, 6, 0, 7);
    run("", "lo$", 1, 3, 0, 4);
    run("", "o.w", 1, 4, 0, 5);
    run("", "xyz", 0, 0, 0, 11);
    run("", "d", 1, 10, 0, 11);
    run("", "ld$", 1, 9, 0, 10);
    run("", "abcdefghi", 0, 0, 1, 0);
    run("", "wor", 1, 6, 0, 7);
    run("", "$", 0, 0, 0, 0);
`ifdef SME_NOCASE_EN
    run("Hello", "hE", 1, 0, 0, 1);
`else
    run("Hello", "hE", 0, 0, 0, 5);
`endif

    // Both strobes high inside a string burst: character belongs to the string.
    send("ab", 1'b1);
    chardata = 8'h63; isstring = 1'b1; ispattern = 1'b1;
    @(posedge clk); #1;
    run("d", "bc", 1, 1, 0, 2);

    run("abcdefghijklmnopqrstuvwxyz0123456", "a", 0, 0, 1, 0);
    run("ab", "b", 1, 1, 0, 2);

    // Reset during SEARCH cycle 2: no result, outputs cleared.
    send("hello world", 1'b1);
    send("xyz", 1'b0);
    for (int i = 0; i < 50 && !busy; i++) begin
      @(posedge clk); #1;
    end
    chk("search_started", int'(busy), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_valid", int'(valid), 0);
    chk("abort_match", int'(match), 0);
    chk("abort_index", int'(match_index), 0);
    chk("abort_error", int'(error), 0);
    chk("abort_busy", int'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run("abc", "c", 1, 2, 0, 3);

    repeat (20) @(posedge clk);
    #1;
    chk("leftover_expected", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
